// File: rtl/scancode_event_fifo.sv
// PS/2 set-2 scan-code decoder (plain, E0, F0, E1 pause) feeding a valid/ready event FIFO.
// Optional typematic-repeat suppression when KEY_REPEAT_FILTER_EN is defined.
module scancode_event_fifo #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MAX_CODE    = 131,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter logic [8:0]  PAUSE_CODE  = 9'h1E1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          din_new,
    input  logic [7:0]                    din,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [8:0]                    ev_code,
    output logic                          ev_brk,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REL     = 3'd1,
        EXT     = 3'd2,
        EXT_REL = 3'd3,
        PAUSE   = 3'd4
    } state_t;

    state_t          state;
    logic [2:0]      pause_cnt;
    logic [TW-1:0]   timer;

    logic            is_code;
    logic            dec_vld;
    logic [8:0]      dec_code;
    logic            dec_brk;
    logic            push;

    logic            pend_vld;
    logic [8:0]      pend_code;
    logic            pend_brk;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_next;
    logic [CW-1:0]   cnt_after_pop;
    logic [CW-1:0]   cnt_next;
    logic            pop;
    logic            full;
    logic            wr_en;

    assign is_code = (din != 8'h00) && (32'(din) <= MAX_CODE);

    // Decode the byte arriving this cycle into a raw event
    always_comb begin
        dec_vld  = 1'b0;
        dec_code = 9'd0;
        dec_brk  = 1'b0;
        if (din_new) begin
            case (state)
                IDLE:    if (is_code) begin dec_vld = 1'b1; dec_code = {1'b0, din}; end
                REL:     if (is_code) begin dec_vld = 1'b1; dec_code = {1'b0, din}; dec_brk = 1'b1; end
                EXT:     if (is_code) begin dec_vld = 1'b1; dec_code = {1'b1, din}; end
                EXT_REL: if (is_code) begin dec_vld = 1'b1; dec_code = {1'b1, din}; dec_brk = 1'b1; end
                PAUSE:   if (pause_cnt == 3'd1) begin dec_vld = 1'b1; dec_code = PAUSE_CODE; end
                default: ;
            endcase
        end
    end

`ifdef KEY_REPEAT_FILTER_EN
    logic [511:0] key_down;

    // Pause events only occur from the PAUSE state and bypass the key map
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            key_down <= '0;
        else if (dec_vld && (state != PAUSE))
            key_down[dec_code] <= ~dec_brk;
    end

    assign push = dec_vld && !((state != PAUSE) && !dec_brk && key_down[dec_code]);
`else
    assign push = dec_vld;
`endif

    // Prefix sequencer with idle timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pause_cnt <= 3'd0;
            timer     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (din_new) begin
                        case (din)
                            8'hF0: state <= REL;
                            8'hE0: state <= EXT;
                            8'hE1: begin state <= PAUSE; pause_cnt <= 3'd7; end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    if (din_new) begin
                        timer <= '0;
                        case (state)
                            EXT:     state <= (din == 8'hF0) ? EXT_REL : IDLE;
                            PAUSE: begin
                                if (pause_cnt == 3'd1) state <= IDLE;
                                pause_cnt <= pause_cnt - 3'd1;
                            end
                            default: state <= IDLE;
                        endcase
                    end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
            endcase
        end
    end

    // One-cycle staging register keeps din off the output path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld  <= 1'b0;
            pend_code <= 9'd0;
            pend_brk  <= 1'b0;
        end else begin
            pend_vld  <= push;
            pend_code <= dec_code;
            pend_brk  <= dec_brk;
        end
    end

    assign pop           = ev_valid & ev_ready;
    assign full          = (ev_count == CW'(FIFO_DEPTH));
    assign wr_en         = pend_vld && (!full || pop);
    assign rd_next       = pop ? rd_ptr + AW'(1) : rd_ptr;
    assign cnt_after_pop = ev_count - CW'(pop);
    assign cnt_next      = cnt_after_pop + CW'(wr_en);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {pend_brk, pend_code};
    end

    // Pointers, occupancy, sticky overflow and registered head
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            ev_count <= '0;
            ev_valid <= 1'b0;
            ev_code  <= 9'd0;
            ev_brk   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_ptr   <= rd_next;
            ev_count <= cnt_next;
            ev_valid <= (cnt_next != '0);
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (cnt_after_pop != '0) begin
                ev_brk  <= mem[rd_next][9];
                ev_code <= mem[rd_next][8:0];
            end else if (wr_en) begin
                ev_brk  <= pend_brk;
                ev_code <= pend_code;
            end
            if (pend_vld && !wr_en)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scancode_event_fifo.sv
// Directed bench for scancode_event_fifo; expectations adapt to KEY_REPEAT_FILTER_EN.
module tb_scancode_event_fifo;

    localparam int unsigned TO = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       din_new;
    logic [7:0] din;
    logic       ev_valid;
    logic       ev_ready;
    logic [8:0] ev_code;
    logic       ev_brk;
    logic [2:0] ev_count;
    logic       overflow;
    logic       overflow_clr;

    int checks = 0;
    int errors = 0;

    scancode_event_fifo #(
        .FIFO_DEPTH (4),
        .MAX_CODE   (131),
        .TIMEOUT_CYC(TO),
        .PAUSE_CODE (9'h1E1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din_new     (din_new),
        .din         (din),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_code     (ev_code),
        .ev_brk      (ev_brk),
        .ev_count    (ev_count),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the byte was sampled
    task automatic send_byte(input logic [7:0] b);
        din     = b;
        din_new = 1'b1;
        @(negedge clk);
        din_new = 1'b0;
    endtask

    // Wait (bounded) for the head event, check it, then pop it
    task automatic expect_event(input string tag, input logic [8:0] code, input logic brk);
        int n = 0;
        while (!ev_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check({tag, "_code"}, 32'(ev_code), 32'(code));
        check({tag, "_brk"}, 32'(ev_brk), 32'(brk));
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic expect_empty(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_count"}, 32'(ev_count), 32'd0);
        check({tag, "_valid"}, 32'(ev_valid), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        din_new      = 1'b0;
        din          = 8'h00;
        ev_ready     = 1'b0;
        overflow_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_code", 32'(ev_code), 32'd0);
        check("rst_brk", 32'(ev_brk), 32'd0);
        check("rst_count", 32'(ev_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Plain make with two-cycle latency and stalled consumer
        send_byte(8'h1C);
        check("lat_early", 32'(ev_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(ev_valid), 32'd1);
        check("lat_code", 32'(ev_code), 32'h01C);
        check("lat_brk", 32'(ev_brk), 32'd0);
        @(negedge clk);
        check("stall_hold", 32'(ev_valid), 32'd1);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        check("pop_empty", 32'(ev_valid), 32'd0);
        check("pop_hold_code", 32'(ev_code), 32'h01C);

        // Extended break
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        expect_event("ext_brk", 9'h175, 1'b1);
        expect_empty("ext_brk_only");

        // E0 followed by OTHER drops back to IDLE
        send_byte(8'hE0); send_byte(8'hAA);
        expect_empty("e0_aa");
        send_byte(8'h1A);
        expect_event("after_e0aa", 9'h01A, 1'b0);

        // Pause sequence yields a single make
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        expect_event("pause", 9'h1E1, 1'b0);
        expect_empty("pause_only");
        send_byte(8'h1B);
        expect_event("after_pause", 9'h01B, 1'b0);

        // F0 followed by a full timeout window is abandoned
        send_byte(8'hF0);
        repeat (TO) @(negedge clk);
        send_byte(8'h15);
        expect_event("timeout", 9'h015, 1'b0);

        // One clock short of the timeout still completes the release
        send_byte(8'hF0);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h16);
        expect_event("no_timeout", 9'h016, 1'b1);

        // MAX_CODE boundary
        send_byte(8'h83);
        expect_event("max_code", 9'h083, 1'b0);
        send_byte(8'h84);
        expect_empty("over_max");

        // Back-to-back bytes
        din = 8'h22; din_new = 1'b1;
        @(negedge clk);
        din = 8'h32;
        @(negedge clk);
        din_new = 1'b0;
        @(negedge clk);
        check("b2b_count", 32'(ev_count), 32'd2);
        expect_event("b2b_0", 9'h022, 1'b0);
        expect_event("b2b_1", 9'h032, 1'b0);

        // Overflow with stalled consumer
        send_byte(8'h21); send_byte(8'h23); send_byte(8'h24);
        send_byte(8'h25); send_byte(8'h26);
        repeat (2) @(negedge clk);
        check("ovf_count", 32'(ev_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        expect_event("ovf_0", 9'h021, 1'b0);
        expect_event("ovf_1", 9'h023, 1'b0);
        expect_event("ovf_2", 9'h024, 1'b0);
        expect_event("ovf_3", 9'h025, 1'b0);
        expect_empty("ovf_drained");
        check("ovf_sticky", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Typematic repeat handling
        send_byte(8'h2B); send_byte(8'h2B); send_byte(8'h2B);
        send_byte(8'hF0); send_byte(8'h2B);
        repeat (2) @(negedge clk);
`ifdef KEY_REPEAT_FILTER_EN
        check("rep_count", 32'(ev_count), 32'd2);
        expect_event("rep_make", 9'h02B, 1'b0);
        expect_event("rep_brk", 9'h02B, 1'b1);
`else
        check("rep_count", 32'(ev_count), 32'd4);
        expect_event("rep_make0", 9'h02B, 1'b0);
        expect_event("rep_make1", 9'h02B, 1'b0);
        expect_event("rep_make2", 9'h02B, 1'b0);
        expect_event("rep_brk", 9'h02B, 1'b1);
`endif
        expect_empty("rep_drained");
        check("rep_no_ovf", 32'(overflow), 32'd0);

        // Reset mid-sequence discards buffered events and prefixes
        send_byte(8'h2D);
        send_byte(8'hE0);
        reset = 1'b1;
        #1;
        check("mrst_valid", 32'(ev_valid), 32'd0);
        check("mrst_count", 32'(ev_count), 32'd0);
        check("mrst_code", 32'(ev_code), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'h2C);
        expect_event("after_rst", 9'h02C, 1'b0);
        expect_empty("after_rst_only");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
